unidad_control: RTL

Sequencer driving the register bank and ALU of the second-delivery datapath. It runs a small program of 8-bit instructions held in an internal instruction memory. For each instruction it presents `instr` and asserts `init` so the bank decodes and reads operands, then starts the ALU and captures the 4-bit result. It then writes the result back with `rd` and waits for the bank's `done` before fetching the next instruction.

---
 rtl/unidad_control.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/unidad_control.sv
// unidad_control: sequencer for the register bank and ALU of the datapath.
// Runs PROG_LEN 8-bit instructions from an internal memory. For each
// instruction it runs decode (init, 2 cycles), ALU start (alu_init, 1 cycle),
// waits for alu_done, writes back (rd, 1 cycle), and then waits for done.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   start                 run request (IDLE only)
//   prog_we/addr/data     instruction memory write port (IDLE only)
//   instr, init           instruction and decode/read strobe to the bank
//   alu_init              ALU start pulse
//   alu_done, alu_result  ALU handshake and result
//   data_result, rd       write-back data and strobe to the bank
//   done                  bank write acknowledge
//   busy, fin, error, pc  status: running, run finished, sticky timeout, address
module unidad_control #(
    parameter int unsigned PROG_LEN = 8,
    parameter int unsigned PC_W     = 3,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            prog_we,
    input  logic [PC_W-1:0] prog_addr,
    input  logic [7:0]      prog_data,
    output logic [7:0]      instr,
    output logic            init,
    output logic            alu_init,
    input  logic            alu_done,
    input  logic [3:0]      alu_result,
    output logic [3:0]      data_result,
    output logic            rd,
    input  logic            done,
    output logic            busy,
    output logic            fin,
    output logic            error,
    output logic [PC_W-1:0] pc
);

    localparam int unsigned TmoW = $clog2(TIMEOUT + 1);
    localparam logic [PC_W-1:0] FirstPc = '0;
    localparam logic [PC_W-1:0] LastPc  = PC_W'(PROG_LEN - 1);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StDecode,
        StExec,
        StWaitAlu,
        StWrite,
        StWaitWb
    } state_e;

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] pc_inc;
    logic [7:0]      instr_q, instr_d;
    logic [3:0]      data_q, data_d;
    logic            error_q, error_d;
    logic            fin_q, fin_d;
    logic [TmoW-1:0] tmo_q, tmo_d;
    logic            sub_q, sub_d;

    // Not reset: program survives a reset.
    logic [7:0] imem [2**PC_W];

    always_ff @(posedge clk) begin
        if (state_q == StIdle && prog_we) begin
            imem[prog_addr] <= prog_data;
        end
    end

    assign pc_inc = pc_q + PC_W'(1);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        data_d  = data_q;
        error_d = error_q;
        fin_d   = 1'b0;
        tmo_d   = '0;      // clears on every state change
        sub_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start && !prog_we) begin
                    error_d = 1'b0;
                    pc_d    = FirstPc;
                    instr_d = imem[FirstPc];
                    state_d = StDecode;
                end
            end
            StDecode: begin
                // First cycle: bank latches addresses; second: operands.
                if (!sub_q) begin
                    sub_d = 1'b1;
                end else begin
                    state_d = StExec;
                end
            end
            StExec: begin
                state_d = StWaitAlu;
            end
            StWaitAlu: begin
                if (alu_done) begin
                    data_d  = alu_result;
                    state_d = StWrite;
                end else if (tmo_q == TmoLast) begin
                    error_d = 1'b1;
                    state_d = StIdle;
                end else begin
                    tmo_d = tmo_q + TmoW'(1);
                end
            end
            StWrite: begin
                state_d = StWaitWb;
            end
            StWaitWb: begin
                if (done) begin
                    if (pc_q == LastPc) begin
                        fin_d   = 1'b1;
                        state_d = StIdle;
                    end else begin
                        pc_d    = pc_inc;
                        instr_d = imem[pc_inc];
                        state_d = StDecode;
                    end
                end else if (tmo_q == TmoLast) begin
                    error_d = 1'b1;
                    state_d = StIdle;
                end else begin
                    tmo_d = tmo_q + TmoW'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            pc_q    <= '0;
            instr_q <= '0;
            data_q  <= '0;
            error_q <= 1'b0;
            fin_q   <= 1'b0;
            tmo_q   <= '0;
            sub_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            data_q  <= data_d;
            error_q <= error_d;
            fin_q   <= fin_d;
            tmo_q   <= tmo_d;
            sub_q   <= sub_d;
        end
    end

    // Strobes decode the registered state, so reset drops them at once.
    assign init        = (state_q == StDecode);
    assign alu_init    = (state_q == StExec);
    assign rd          = (state_q == StWrite);
    assign busy        = (state_q != StIdle);
    assign fin         = fin_q;
    assign error       = error_q;
    assign pc          = pc_q;
    assign instr       = instr_q;
    assign data_result = data_q;

endmodule
